// File: rtl/voice_bus_capture.sv
// Bus front end of the voice core: resynchronises the cartridge header, glitch-filters WR
// and turns each qualified write into one command word on a valid/ready handshake.
module voice_bus_capture #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter int   SETTLE      = 2,
    parameter logic CS_ACTIVE   = 1'b1
) (
    input  logic       clk12m,
    input  logic       res_n_i,
    input  logic       cart_wr_n_i,
    input  logic       cart_cs_i,
    input  logic [7:0] cart_addr_i,
    input  logic       cart_d5_i,
    input  logic       voice_ldq_i,
    output logic       cmd_valid_o,
    input  logic       cmd_ready_i,
    output logic [7:0] cmd_addr_o,
    output logic       cmd_d5_o,
    output logic       cart_ldq_o,
    output logic       overrun_o,
    input  logic       overrun_clr_i
);

    localparam int CNT_MAX = (FILTER_LEN > SETTLE) ? FILTER_LEN : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW_FILT,
        S_SETTLE,
        S_CAPTURE,
        S_WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0]      wrSync_q;
    logic [SYNC_STAGES-1:0]      csSync_q;
    logic [SYNC_STAGES-1:0]      d5Sync_q;
    logic [SYNC_STAGES-1:0][7:0] addrSync_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic [7:0]        addr_q, addr_d;
    logic              d5_q, d5_d;
    logic              overrun_q, overrun_d;
    logic              ldq_q;
    logic              issue;

    logic       wrS, csS, d5S;
    logic [7:0] addrS;

    assign wrS   = wrSync_q[SYNC_STAGES-1];
    assign csS   = csSync_q[SYNC_STAGES-1];
    assign d5S   = d5Sync_q[SYNC_STAGES-1];
    assign addrS = addrSync_q[SYNC_STAGES-1];

    // WR strobe qualifier: filter the low level, let the bus settle, capture once,
    // then insist on a clean high level before arming for the next strobe.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!wrS) begin
                    state_d = S_LOW_FILT;
                    count_d = CNT_W'(1);
                end
            end
            S_LOW_FILT: begin
                if (wrS) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (count_q == FILT_LAST) begin
                    state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (wrS) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (count_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                issue   = (csS == CS_ACTIVE);
                state_d = S_WAIT_HIGH;
                count_d = '0;
            end
            S_WAIT_HIGH: begin
                if (!wrS) begin
                    count_d = '0;
                end else if (count_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT_HIGH;
                count_d = '0;
            end
        endcase
    end

    // A new word may replace one leaving this cycle; otherwise it is dropped and flagged.
    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        d5_d      = d5_q;
        overrun_d = overrun_q;
        if (valid_q && cmd_ready_i) begin
            valid_d = 1'b0;
        end
        if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
        if (issue) begin
            if (!valid_q || cmd_ready_i) begin
                valid_d = 1'b1;
                addr_d  = addrS;
                d5_d    = d5S;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk12m) begin
        if (!res_n_i) begin
            wrSync_q   <= '1;
            csSync_q   <= {SYNC_STAGES{~CS_ACTIVE}};
            d5Sync_q   <= '0;
            addrSync_q <= '0;
            state_q    <= S_WAIT_HIGH;
            count_q    <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            d5_q       <= 1'b0;
            overrun_q  <= 1'b0;
            ldq_q      <= 1'b0;
        end else begin
            wrSync_q   <= {wrSync_q[SYNC_STAGES-2:0], cart_wr_n_i};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cart_cs_i};
            d5Sync_q   <= {d5Sync_q[SYNC_STAGES-2:0], cart_d5_i};
            addrSync_q <= {addrSync_q[SYNC_STAGES-2:0], cart_addr_i};
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            d5_q       <= d5_d;
            overrun_q  <= overrun_d;
            ldq_q      <= voice_ldq_i;
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_d5_o    = d5_q;
    assign overrun_o   = overrun_q;
    assign cart_ldq_o  = ldq_q;

endmodule

// File: tb/tb_voice_bus_capture.sv
// Self-checking bench for voice_bus_capture: directed scenarios plus randomized WR pulses
// compared against a pulse-length rule model.
module tb_voice_bus_capture;

    localparam int FILTER_LEN = 4;
    localparam int SETTLE     = 2;
    // A low strobe produces a command only if it lasts at least this many cycles.
    localparam int MIN_LOW    = FILTER_LEN + SETTLE + 1;

    logic       clk = 1'b0;
    logic       resN;
    logic       wrN;
    logic       cartCs;
    logic [7:0] cartAddr;
    logic       cartD5;
    logic       voiceLdq;
    logic       validO;
    logic       readyI;
    logic [7:0] addrO;
    logic       d5O;
    logic       ldqO;
    logic       overrunO;
    logic       overrunClr;

    int totalChecks = 0;
    int badChecks   = 0;
    int validCycles = 0;
    int overrunCycles = 0;
    logic [8:0] obsQ[$];
    logic [8:0] expQ[$];

    always #5 clk = ~clk;

    voice_bus_capture dut (
        .clk12m        (clk),
        .res_n_i       (resN),
        .cart_wr_n_i   (wrN),
        .cart_cs_i     (cartCs),
        .cart_addr_i   (cartAddr),
        .cart_d5_i     (cartD5),
        .voice_ldq_i   (voiceLdq),
        .cmd_valid_o   (validO),
        .cmd_ready_i   (readyI),
        .cmd_addr_o    (addrO),
        .cmd_d5_o      (d5O),
        .cart_ldq_o    (ldqO),
        .overrun_o     (overrunO),
        .overrun_clr_i (overrunClr)
    );

    // Transfers are recorded mid-cycle, the edge after which they complete.
    always @(negedge clk) begin
        if (validO) begin
            validCycles++;
            if (readyI) obsQ.push_back({addrO, d5O});
        end
        if (overrunO) overrunCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int lowLen, input int gap, input logic cs,
                                 input logic [7:0] addr, input logic d5);
        @(posedge clk);
        #1;
        cartCs   = cs;
        cartAddr = addr;
        cartD5   = d5;
        wrN      = 1'b0;
        repeat (lowLen) @(posedge clk);
        #1;
        wrN = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        resN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resN = 1'b1;
    endtask

    task automatic expectOneWord(input string tag, input logic [8:0] word);
        checkOutput({tag, "_count"}, obsQ.size(), 1);
        if (obsQ.size() > 0) checkOutput({tag, "_word"}, obsQ.pop_front(), word);
        obsQ.delete();
    endtask

    initial begin
        int latency;
        int validHigh;
        int startCount;
        int lowLen;
        logic cs;
        logic d5;
        logic [7:0] addr;
        logic prevLdq;
        logic newLdq;

        resN = 1'b0; wrN = 1'b1; cartCs = 1'b0; cartAddr = 8'h00; cartD5 = 1'b0;
        voiceLdq = 1'b1; readyI = 1'b0; overrunClr = 1'b0;

        // Reset state
        resetDut();
        checkOutput("rst_valid", validO, 0);
        checkOutput("rst_addr", addrO, 0);
        checkOutput("rst_overrun", overrunO, 0);

        // Single long write, latency and one-cycle valid
        readyI = 1'b1; cartCs = 1'b1; cartAddr = 8'h2B; cartD5 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        wrN = 1'b0;
        latency = 0;
        validHigh = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (validO) begin
                if (latency == 0) latency = k;
                validHigh++;
            end
        end
        wrN = 1'b1;
        repeat (8) @(posedge clk);
        checkOutput("t1_latency_in_window", (latency >= 8 && latency <= 10), 1);
        checkOutput("t1_valid_cycles", validHigh, 1);
        expectOneWord("t1", {8'h2B, 1'b1});

        // Glitch filter thresholds
        applyStimulus(3, 8, 1'b1, 8'h11, 1'b0);
        applyStimulus(5, 8, 1'b1, 8'h12, 1'b0);
        checkOutput("t2_short_pulses", obsQ.size(), 0);
        applyStimulus(7, 8, 1'b1, 8'h13, 1'b1);
        expectOneWord("t2_seven", {8'h13, 1'b1});

        // Chip select gating
        startCount = validCycles;
        applyStimulus(10, 8, 1'b0, 8'h44, 1'b1);
        checkOutput("t3_cs0_valid", validCycles - startCount, 0);
        checkOutput("t3_cs0_overrun", overrunO, 0);
        applyStimulus(10, 8, 1'b1, 8'h45, 1'b0);
        expectOneWord("t3_cs1", {8'h45, 1'b0});

        // Randomized pulses against the pulse-length rule
        obsQ.delete();
        expQ.delete();
        for (int i = 0; i < 24; i++) begin
            lowLen = $urandom_range(1, 12);
            cs     = 1'($urandom);
            addr   = 8'($urandom);
            d5     = 1'($urandom);
            if (lowLen >= MIN_LOW && cs) expQ.push_back({addr, d5});
            applyStimulus(lowLen, $urandom_range(6, 10), cs, addr, d5);
        end
        checkOutput("rand_count", obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkOutput($sformatf("rand_word%0d", i), obsQ[i], expQ[i]);
        end
        obsQ.delete();

        // Back-pressure and overrun
        readyI = 1'b0;
        applyStimulus(10, 8, 1'b1, 8'h10, 1'b0);
        applyStimulus(10, 8, 1'b1, 8'h20, 1'b1);
        #1;
        checkOutput("t4_held_valid", validO, 1);
        checkOutput("t4_held_addr", addrO, 8'h10);
        checkOutput("t4_overrun_set", overrunO, 1);
        @(posedge clk);
        #1;
        readyI = 1'b1;
        @(posedge clk);
        #1;
        readyI = 1'b0;
        checkOutput("t4_valid_drop", validO, 0);
        expectOneWord("t4_transfer", {8'h10, 1'b0});
        checkOutput("t4_overrun_sticky", overrunO, 1);
        overrunClr = 1'b1;
        @(posedge clk);
        #1;
        overrunClr = 1'b0;
        checkOutput("t4_overrun_clr", overrunO, 0);
        applyStimulus(10, 8, 1'b1, 8'h30, 1'b1);
        #1;
        overrunClr = 1'b1;
        startCount = overrunCycles;
        applyStimulus(10, 8, 1'b1, 8'h40, 1'b0);
        #1;
        overrunClr = 1'b0;
        checkOutput("t4_set_wins_cycles", overrunCycles - startCount, 1);
        applyStimulus(10, 8, 1'b1, 8'h50, 1'b0);
        #1;
        checkOutput("t4_overrun_again", overrunO, 1);
        checkOutput("t4_still_0x30", addrO, 8'h30);

        // Reset during SETTLE with WR held low
        voiceLdq = 1'b1;
        @(posedge clk);
        #1;
        cartAddr = 8'h77;
        wrN = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        resN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_rst_valid", validO, 0);
        checkOutput("t5_rst_addr", addrO, 0);
        checkOutput("t5_rst_d5", d5O, 0);
        checkOutput("t5_rst_ldq", ldqO, 0);
        checkOutput("t5_rst_overrun", overrunO, 0);
        repeat (2) @(posedge clk);
        #1;
        resN = 1'b1;
        readyI = 1'b1;
        obsQ.delete();
        startCount = validCycles;
        repeat (20) @(posedge clk);
        checkOutput("t5_no_cmd_while_low", validCycles - startCount, 0);
        #1;
        wrN = 1'b1;
        repeat (6) @(posedge clk);
        applyStimulus(10, 8, 1'b1, 8'h5A, 1'b0);
        expectOneWord("t5_after_rearm", {8'h5A, 1'b0});

        // LDQ passthrough, exactly one cycle late
        @(posedge clk);
        #1;
        prevLdq = voiceLdq;
        for (int i = 0; i < 16; i++) begin
            newLdq = (i % 2 == 0) ? ~prevLdq : 1'($urandom);
            voiceLdq = newLdq;
            #1;
            checkOutput("t6_ldq_before_edge", ldqO, prevLdq);
            @(posedge clk);
            #1;
            checkOutput("t6_ldq_after_edge", ldqO, newLdq);
            prevLdq = newLdq;
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
